// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-controller arbiter.
package mem_arbiter_pkg;

  // funct3 width/sign codes understood by the memory controller
  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101
  } mem_op_e;

  // Which requester currently holds the controller
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSB  = 2'd2
  } owner_e;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Width of the starvation counter; covers limits up to 7
  localparam int STARVE_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// LSB-first priority select with a starvation bound protecting fetch.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic lsb_req,
  input  logic grant_if,
  input  logic grant_lsb,
  input  logic clear,
  output logic sel_if,
  output logic sel_lsb
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_reg;

  // LSB wins unless fetch is waiting and LSB has already used up its run
  always_comb begin
    sel_lsb = lsb_req && (!if_req || (starve_cnt_reg < LIMIT));
    sel_if  = if_req && !sel_lsb;
  end

  // Count consecutive LSB grants taken while fetch was waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (clear || grant_if) begin
      starve_cnt_reg <= '0;
    end else if (grant_lsb) begin
      if (!if_req) begin
        starve_cnt_reg <= '0;
      end else if (starve_cnt_reg != LIMIT) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Sequences the shared byte-serial memory controller between the
// instruction fetcher and the load/store buffer, one request at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_grant,
  output logic        if_done,
  output logic [31:0] if_data,
  output logic [31:0] if_data_addr,
  input  logic        lsb_req,
  input  logic        lsb_is_store,
  input  logic [2:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_grant,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  output logic        mc_valid,
  output logic        mc_is_store,
  output logic [2:0]  mc_op,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  input  logic        mc_accept,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  state_e state_reg;
  owner_e owner_reg;
  logic   flushed_reg;   // store saw a flush while still in ISSUE

  logic sel_if;
  logic sel_lsb;
  logic store_owner;
  logic do_abandon;
  logic grant_if;
  logic grant_lsb;

  // A store in flight must always complete; fetches and loads may be dropped
  assign store_owner = (owner_reg == OWN_LSB) && mc_is_store;
  assign do_abandon  = rdy && rob_clear && !store_owner &&
                       ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT));
  assign grant_lsb   = rdy && !rob_clear && (state_reg == ST_IDLE) && sel_lsb;
  assign grant_if    = rdy && !rob_clear && (state_reg == ST_IDLE) && sel_if;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .lsb_req   (lsb_req),
    .grant_if  (grant_if),
    .grant_lsb (grant_lsb),
    .clear     (do_abandon),
    .sel_if    (sel_if),
    .sel_lsb   (sel_lsb)
  );

  // Main sequencer: latch, issue, wait for completion, route the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= OWN_NONE;
      flushed_reg  <= 1'b0;
      if_grant     <= 1'b0;
      if_done      <= 1'b0;
      if_data      <= '0;
      if_data_addr <= '0;
      lsb_grant    <= 1'b0;
      lsb_done     <= 1'b0;
      lsb_rdata    <= '0;
      mc_valid     <= 1'b0;
      mc_is_store  <= 1'b0;
      mc_op        <= '0;
      mc_addr      <= '0;
      mc_wdata     <= '0;
    end else if (rdy) begin
      if_grant  <= 1'b0;
      lsb_grant <= 1'b0;
      if_done   <= 1'b0;
      lsb_done  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_lsb) begin
            owner_reg   <= OWN_LSB;
            flushed_reg <= 1'b0;
            mc_valid    <= 1'b1;
            mc_is_store <= lsb_is_store;
            mc_op       <= lsb_op;
            mc_addr     <= lsb_addr;
            mc_wdata    <= lsb_wdata;
            lsb_grant   <= 1'b1;
            state_reg   <= ST_ISSUE;
          end else if (grant_if) begin
            owner_reg   <= OWN_IF;
            flushed_reg <= 1'b0;
            mc_valid    <= 1'b1;
            mc_is_store <= 1'b0;
            mc_op       <= OP_LW;
            mc_addr     <= if_addr;
            mc_wdata    <= '0;
            if_grant    <= 1'b1;
            state_reg   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (do_abandon) begin
            mc_valid  <= 1'b0;
            owner_reg <= OWN_NONE;
            state_reg <= ST_IDLE;
          end else begin
            if (rob_clear) begin
              flushed_reg <= 1'b1;
            end
            if (mc_accept) begin
              mc_valid  <= 1'b0;
              state_reg <= (flushed_reg || rob_clear) ? ST_DRAIN : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (do_abandon) begin
            owner_reg <= OWN_NONE;
            state_reg <= ST_IDLE;
          end else if (mc_done) begin
            if (owner_reg == OWN_IF) begin
              if_data      <= mc_rdata;
              if_data_addr <= mc_addr;
              if_done      <= 1'b1;
            end else begin
              if (!mc_is_store) begin
                lsb_rdata <= mc_rdata;
              end
              lsb_done <= 1'b1;
            end
            owner_reg <= OWN_NONE;
            state_reg <= ST_IDLE;
          end else if (rob_clear) begin
            state_reg <= ST_DRAIN;
          end
        end
        default: begin
          if (mc_done) begin
            lsb_done  <= 1'b1;
            owner_reg <= OWN_NONE;
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rob_clear;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_grant;
  logic        if_done;
  logic [31:0] if_data;
  logic [31:0] if_data_addr;
  logic        lsb_req;
  logic        lsb_is_store;
  logic [2:0]  lsb_op;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_grant;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        mc_valid;
  logic        mc_is_store;
  logic [2:0]  mc_op;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic        mc_accept;
  logic        mc_done;
  logic [31:0] mc_rdata;

  int checks;
  int failures;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .rob_clear    (rob_clear),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_grant     (if_grant),
    .if_done      (if_done),
    .if_data      (if_data),
    .if_data_addr (if_data_addr),
    .lsb_req      (lsb_req),
    .lsb_is_store (lsb_is_store),
    .lsb_op       (lsb_op),
    .lsb_addr     (lsb_addr),
    .lsb_wdata    (lsb_wdata),
    .lsb_grant    (lsb_grant),
    .lsb_done     (lsb_done),
    .lsb_rdata    (lsb_rdata),
    .mc_valid     (mc_valid),
    .mc_is_store  (mc_is_store),
    .mc_op        (mc_op),
    .mc_addr      (mc_addr),
    .mc_wdata     (mc_wdata),
    .mc_accept    (mc_accept),
    .mc_done      (mc_done),
    .mc_rdata     (mc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  bit exp_lsb [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int exp_cnt [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

  initial begin
    int n;
    checks = 0; failures = 0;
    rst = 1; rdy = 1; rob_clear = 0;
    if_req = 0; if_addr = 0;
    lsb_req = 0; lsb_is_store = 0; lsb_op = 0; lsb_addr = 0; lsb_wdata = 0;
    mc_accept = 0; mc_done = 0; mc_rdata = 0;
    step(); step();
    rst = 0;
    chk("rst_if_grant", {31'b0, if_grant}, 0);
    chk("rst_lsb_grant", {31'b0, lsb_grant}, 0);
    chk("rst_mc_valid", {31'b0, mc_valid}, 0);
    chk("rst_mc_addr", mc_addr, 0);
    chk("rst_state", 32'(dut.state_reg), 0);
    chk("rst_starve", 32'(dut.u_pick.starve_cnt_reg), 0);

    // ---- 1: single fetch ----
    if_req = 1; if_addr = 32'h100;
    step();
    chk("t1_if_grant", {31'b0, if_grant}, 1);
    chk("t1_mc_valid", {31'b0, mc_valid}, 1);
    chk("t1_mc_addr", mc_addr, 32'h100);
    chk("t1_mc_op", {29'b0, mc_op}, 32'h2);
    chk("t1_mc_is_store", {31'b0, mc_is_store}, 0);
    if_req = 0; mc_accept = 1;
    step();
    chk("t1_grant_pulse", {31'b0, if_grant}, 0);
    chk("t1_mc_valid_off", {31'b0, mc_valid}, 0);
    mc_accept = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_no_done_yet", {31'b0, if_done}, 0);
    end
    mc_done = 1; mc_rdata = 32'h00A00093;
    step();
    mc_done = 0;
    chk("t1_if_done", {31'b0, if_done}, 1);
    chk("t1_if_data", if_data, 32'h00A00093);
    chk("t1_if_data_addr", if_data_addr, 32'h100);
    step();
    chk("t1_done_pulse", {31'b0, if_done}, 0);

    // ---- 2: starvation bound ----
    if_req = 1; if_addr = 32'h200;
    lsb_req = 1; lsb_is_store = 0; lsb_op = 3'b010; lsb_addr = 32'h1000;
    mc_accept = 1; mc_done = 1; mc_rdata = 32'h11111111;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      step();
      while (!(if_grant || lsb_grant) && n < 10) begin
        step();
        n++;
      end
      chk("t2_grant_seen", {31'b0, (if_grant | lsb_grant)}, 1);
      chk("t2_grant_is_lsb", {31'b0, lsb_grant}, {31'b0, exp_lsb[i]});
      chk("t2_starve_cnt", 32'(dut.u_pick.starve_cnt_reg), exp_cnt[i]);
    end
    if_req = 0; lsb_req = 0;
    step(); step();
    chk("t2_last_if_done", {31'b0, if_done}, 1);
    mc_accept = 0; mc_done = 0;
    step();

    // ---- 3: load flushed in WAIT ----
    lsb_req = 1; lsb_is_store = 0; lsb_op = 3'b010; lsb_addr = 32'h2000;
    step();
    chk("t3_lsb_grant", {31'b0, lsb_grant}, 1);
    chk("t3_mc_addr", mc_addr, 32'h2000);
    lsb_req = 0; mc_accept = 1;
    step();
    mc_accept = 0;
    step();
    chk("t3_in_wait", 32'(dut.state_reg), 2);
    rob_clear = 1;
    step();
    rob_clear = 0;
    chk("t3_idle_after_clear", 32'(dut.state_reg), 0);
    chk("t3_no_lsb_done", {31'b0, lsb_done}, 0);
    chk("t3_mc_valid", {31'b0, mc_valid}, 0);
    chk("t3_starve_clr", 32'(dut.u_pick.starve_cnt_reg), 0);
    if_req = 1; if_addr = 32'h400; mc_done = 1; mc_rdata = 32'hBAD0BAD0;
    step();
    chk("t3_late_done_ignored", {31'b0, lsb_done}, 0);
    chk("t3_lsb_rdata_held", lsb_rdata, 32'h11111111);
    chk("t3_if_grant", {31'b0, if_grant}, 1);
    chk("t3_mc_addr_fetch", mc_addr, 32'h400);
    if_req = 0; mc_done = 0; mc_accept = 1;
    step();
    mc_accept = 0; mc_done = 1; mc_rdata = 32'h00000055;
    step();
    mc_done = 0;
    chk("t3_if_done", {31'b0, if_done}, 1);
    chk("t3_if_data", if_data, 32'h00000055);
    step();

    // ---- 4: store flushed in ISSUE drains ----
    lsb_req = 1; lsb_is_store = 1; lsb_op = 3'b010;
    lsb_addr = 32'h3000; lsb_wdata = 32'hDEADBEEF;
    step();
    chk("t4_lsb_grant", {31'b0, lsb_grant}, 1);
    chk("t4_mc_is_store", {31'b0, mc_is_store}, 1);
    chk("t4_mc_wdata", mc_wdata, 32'hDEADBEEF);
    lsb_req = 0; rob_clear = 1;
    step();
    rob_clear = 0;
    chk("t4_valid_held", {31'b0, mc_valid}, 1);
    if_req = 1; if_addr = 32'h600;
    step();
    chk("t4_valid_held2", {31'b0, mc_valid}, 1);
    chk("t4_no_grant_issue", {31'b0, if_grant}, 0);
    mc_accept = 1;
    step();
    mc_accept = 0;
    chk("t4_valid_off", {31'b0, mc_valid}, 0);
    chk("t4_in_drain", 32'(dut.state_reg), 3);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_no_grant_drain", {31'b0, if_grant}, 0);
    end
    mc_done = 1;
    step();
    mc_done = 0;
    chk("t4_lsb_done", {31'b0, lsb_done}, 1);
    chk("t4_no_grant_with_done", {31'b0, if_grant}, 0);
    chk("t4_rdata_kept", lsb_rdata, 32'h11111111);
    step();
    chk("t4_done_pulse", {31'b0, lsb_done}, 0);
    chk("t4_grant_after_done", {31'b0, if_grant}, 1);
    if_req = 0; mc_accept = 1;
    step();
    mc_accept = 0; mc_done = 1; mc_rdata = 32'h66;
    step();
    mc_done = 0;
    step();

    // ---- 5: rdy low during WAIT ----
    if_req = 1; if_addr = 32'h500;
    step();
    if_req = 0; mc_accept = 1;
    step();
    mc_accept = 0;
    rdy = 0; mc_done = 1; mc_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_frozen_no_done", {31'b0, if_done}, 0);
      chk("t5_frozen_state", 32'(dut.state_reg), 2);
    end
    rdy = 1;
    step();
    mc_done = 0;
    chk("t5_if_done", {31'b0, if_done}, 1);
    chk("t5_if_data", if_data, 32'h12345678);
    chk("t5_if_data_addr", if_data_addr, 32'h500);
    step();
    chk("t5_done_pulse", {31'b0, if_done}, 0);

    // ---- 6: reset mid-WAIT ----
    if_req = 1; lsb_req = 1; lsb_is_store = 0; lsb_addr = 32'h7000;
    step();
    chk("t6_lsb_grant", {31'b0, lsb_grant}, 1);
    chk("t6_starve_one", 32'(dut.u_pick.starve_cnt_reg), 1);
    if_req = 0; lsb_req = 0; mc_accept = 1;
    step();
    mc_accept = 0;
    rst = 1;
    step();
    rst = 0;
    chk("t6_state", 32'(dut.state_reg), 0);
    chk("t6_starve", 32'(dut.u_pick.starve_cnt_reg), 0);
    chk("t6_if_data", if_data, 0);
    chk("t6_if_data_addr", if_data_addr, 0);
    chk("t6_lsb_rdata", lsb_rdata, 0);
    chk("t6_mc_addr", mc_addr, 0);
    chk("t6_mc_wdata", mc_wdata, 0);
    chk("t6_flags", {26'b0, if_grant, if_done, lsb_grant, lsb_done, mc_valid, mc_is_store}, 0);
    chk("t6_mc_op", {29'b0, mc_op}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the shared byte-serial memory controller between the instruction fetcher and the load/store buffer (LSB).
- Accepts one request at a time and latches it into holding registers.
- Drives the controller until it signals completion, then returns the result to the owner.
- Applies LSB-first priority with a starvation bound for fetch, and handles RoB flush so that in-flight stores still complete.

Parameters:
STARVE_LIMIT, 4, maximum consecutive LSB grants while a fetch is pending; the next grant is then forced to fetch (range 1..7).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; when low, all state and outputs hold
rob_clear  in  1  RoB flush pulse
if_req  in  1  fetch request, held until if_grant
if_addr  in  32  fetch address
if_grant  out  1  one-cycle pulse: request latched
if_done  out  1  one-cycle pulse: instruction valid
if_data  out  32  fetched instruction
if_data_addr  out  32  address of if_data
lsb_req  in  1  LSB request, held until lsb_grant
lsb_is_store  in  1  1 = store
lsb_op  in  3  funct3 width/sign code
lsb_addr  in  32  data address
lsb_wdata  in  32  store data
lsb_grant  out  1  one-cycle pulse: request latched
lsb_done  out  1  one-cycle pulse: load data valid or store written
lsb_rdata  out  32  load result, already extended
mc_valid  out  1  request to memory controller
mc_is_store  out  1  held request type
mc_op  out  3  held op (fetch uses LW code)
mc_addr  out  32  held address
mc_wdata  out  32  held store data
mc_accept  in  1  controller takes request this cycle
mc_done  in  1  controller finished; mc_rdata valid this cycle
mc_rdata  in  32  controller result

Behaviour:
- All outputs are registered.
- Reset: state IDLE; owner NONE; starve_cnt 0; all outputs 0.
- rst has priority over everything. rdy low freezes the block, including during rob_clear. rob_clear is acted on only when rdy is high.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE arbitration:
  - Pick LSB if lsb_req && (!if_req || starve_cnt < STARVE_LIMIT); else pick fetch if if_req.
  - Latch the request fields, pulse the matching grant next cycle, go to ISSUE.
  - Fetch: mc_op = 3'b010, mc_is_store = 0.
- starve_cnt:
  - +1 on an LSB grant while if_req is high, saturating at STARVE_LIMIT.
  - Cleared on a fetch grant, and cleared when if_req is low at an LSB grant.
- ISSUE: mc_valid = 1 with the held fields. On mc_accept, go to WAIT with mc_valid = 0 next cycle.
- WAIT: on mc_done, capture mc_rdata into if_data or lsb_rdata (if_data_addr = held address), pulse the owner's done next cycle, go to IDLE.
  - The done pulse and a new grant are never in the same cycle; the earliest next grant is the cycle after done.
  - Minimum turnaround, with mc_accept asserted in ISSUE and the shortest mc_done: request cycle t, grant visible t+1, mc_valid t+1, done visible t+3 or later.
- rob_clear with owner = fetch or load, in ISSUE or WAIT:
  - Go to IDLE, mc_valid = 0, no done pulse.
  - A later mc_done for the dropped request is ignored.
  - Requests in the clear cycle are not granted.
  - starve_cnt is cleared.
- rob_clear with owner = store:
  - Go to DRAIN, or stay in ISSUE until accept, then DRAIN.
  - DRAIN waits for mc_done, pulses lsb_done, returns to IDLE.
  - The store is never abandoned.
- rob_clear in IDLE: no grant that cycle.
- rob_clear is not latched: a second clear during DRAIN has no additional effect.
- mc_done in IDLE or ISSUE is illegal and is ignored.
- mc_accept outside ISSUE is ignored.
- if_data and lsb_rdata hold their last value until the next capture.

Decomposition:
- Shared package constants:
  - op codes LB=000, LH=001, LW=010, LBU=100, LHU=101
  - owner codes OWN_NONE, OWN_IF, OWN_LSB
  - FSM state encodings
- Natural sub-module: mem_arb_pick.
  - Combinational priority select plus the registered starve_cnt.
  - Inputs: if_req, lsb_req, grant events, clear.
  - Output: the select.

Test Plan:
1. if_req only, addr 0x100; mc_accept immediate; mc_done after 4 cycles with mc_rdata 0x00A00093 -> if_grant 1 cycle, mc_addr 0x100 / mc_op 010, if_done with if_data 0x00A00093 and if_data_addr 0x100.
2. if_req and lsb_req held continuously, STARVE_LIMIT=4 -> grant order L,L,L,L,F,L,L,L,L,F; starve_cnt returns to 0 after each F.
3. Load lw at 0x2000 in WAIT; rob_clear pulse -> IDLE next cycle, no lsb_done; a late mc_done is ignored; a new if_req is granted the cycle after the clear.
4. Store sw 0xDEADBEEF at 0x3000 in ISSUE, with rob_clear before mc_accept -> mc_valid held until accept, then DRAIN; lsb_done on completion; no request is granted during DRAIN.
5. rdy low for 3 cycles during WAIT while mc_done is asserted -> no state change and no done; done is processed once rdy returns high.
6. rst asserted mid-WAIT -> all outputs 0 next cycle, state IDLE, starve_cnt 0.
